regfile_wb_sched: RTL

Writeback scheduler and pending-write scoreboard for the integer register file. Shares the register file's single write port between two writeback requesters (A: ALU, B: load/store unit) with round-robin arbitration and a valid/ready handshake. Tracks which destination registers have an issued-but-not-committed write so the decode stage can stall on RAW hazards. Sits between the execute/LSU writeback paths and the regfile write port (`dest_en`/`dest_addr`/`dest_data`).

---
 rtl/regfile_wb_sched_if.sv | 48 ++++
 rtl/regfile_wb_sched.sv | 99 +++++++++
 2 files changed

// File: rtl/regfile_wb_sched_if.sv
// Writeback scheduler bundle: decode-side issue/source lookup, the two writeback
// requesters (valid/ready) and the registered regfile write port.
interface regfile_wb_sched_if #(
    parameter int WIDTH      = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
);
    logic                  issue_en;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rs1_fwd;
    logic                  rs2_fwd;
    logic [WIDTH-1:0]      fwd_data;

    // Handshake: a transfer happens in a cycle where x_valid and x_ready are both
    // high. ready depends on valid (arbitration), never the other way round.
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [WIDTH-1:0]      a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [WIDTH-1:0]      b_data;

    logic                  dest_en;
    logic [ADDR_WIDTH-1:0] dest_addr;
    logic [WIDTH-1:0]      dest_data;

    modport slave (
        input  issue_en, issue_addr, rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, fwd_data,
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output dest_en, dest_addr, dest_data
    );

    modport master (
        output issue_en, issue_addr, rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, fwd_data,
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  dest_en, dest_addr, dest_data
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin writeback arbiter for the regfile write port plus pending-write scoreboard.
// Define REGFILE_WB_SCHED_BYPASS_EN to forward the committing value to decode sources.
module regfile_wb_sched #(
    parameter int WIDTH      = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_sched_if.slave  wb
);
    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic                  last_grant_b_q, last_grant_b_d;
    logic                  dest_en_q, dest_en_d;
    logic [ADDR_WIDTH-1:0] dest_addr_q, dest_addr_d;
    logic [WIDTH-1:0]      dest_data_q, dest_data_d;
    logic                  grant_a, grant_b;

    // On a tie the side not granted last wins; no grants at all while in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (wb.a_valid && wb.b_valid) begin
                grant_a = last_grant_b_q;
                grant_b = !last_grant_b_q;
            end else begin
                grant_a = wb.a_valid;
                grant_b = wb.b_valid;
            end
        end
    end

    assign wb.a_ready = grant_a;
    assign wb.b_ready = grant_b;

    always_comb begin
        last_grant_b_d = last_grant_b_q;
        dest_en_d      = 1'b0;
        dest_addr_d    = dest_addr_q;
        dest_data_d    = dest_data_q;
        if (grant_a) begin
            last_grant_b_d = 1'b0;
            dest_en_d      = (wb.a_addr != '0);
            dest_addr_d    = wb.a_addr;
            dest_data_d    = wb.a_data;
        end else if (grant_b) begin
            last_grant_b_d = 1'b1;
            dest_en_d      = (wb.b_addr != '0);
            dest_addr_d    = wb.b_addr;
            dest_data_d    = wb.b_data;
        end

        // Clear before set so a same-cycle reissue of the committing register stays pending.
        busy_d = busy_q;
        if (dest_en_q) busy_d[dest_addr_q] = 1'b0;
        if (wb.issue_en) busy_d[wb.issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            last_grant_b_q <= 1'b1;
            dest_en_q      <= 1'b0;
            dest_addr_q    <= '0;
            dest_data_q    <= '0;
        end else begin
            busy_q         <= busy_d;
            last_grant_b_q <= last_grant_b_d;
            dest_en_q      <= dest_en_d;
            dest_addr_q    <= dest_addr_d;
            dest_data_q    <= dest_data_d;
        end
    end

    assign wb.dest_en   = dest_en_q;
    assign wb.dest_addr = dest_addr_q;
    assign wb.dest_data = dest_data_q;

`ifdef REGFILE_WB_SCHED_BYPASS_EN
    logic rs1_hit, rs2_hit;

    // dest_en never fires for x0, so a hit already implies a nonzero source.
    assign rs1_hit     = dest_en_q && (dest_addr_q == wb.rs1_addr);
    assign rs2_hit     = dest_en_q && (dest_addr_q == wb.rs2_addr);
    assign wb.rs1_busy = busy_q[wb.rs1_addr] && !rs1_hit;
    assign wb.rs2_busy = busy_q[wb.rs2_addr] && !rs2_hit;
    assign wb.rs1_fwd  = rs1_hit;
    assign wb.rs2_fwd  = rs2_hit;
    assign wb.fwd_data = dest_data_q;
`else
    assign wb.rs1_busy = busy_q[wb.rs1_addr];
    assign wb.rs2_busy = busy_q[wb.rs2_addr];
    assign wb.rs1_fwd  = 1'b0;
    assign wb.rs2_fwd  = 1'b0;
    assign wb.fwd_data = '0;
`endif
endmodule
